inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
- Write-side counterpart of the instruction memory read port: fills a writable instruction RAM from an external byte stream, e.g. a UART RX or debug bridge.
- Holds the pipeline CPU in a stalled state while loading and releases it on successful completion.
- Sits between the byte source and the instruction RAM write port; the CPU fetch path keeps using the RAM read port unchanged.

Parameters:
- BASE_ADDR, 32'h00000000, byte address of the first word written; must be word aligned.
- MAX_WORDS, 256, largest legal word count in the header.
- CNT_W, 16, width of the header word count and of the internal word index.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load session.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts the byte this cycle; transfer occurs when byte_valid && byte_ready.
- mem_we  output  1  instruction RAM write enable, one-cycle pulse per word.
- mem_addr  output  32  RAM byte address, word aligned: BASE_ADDR + 4*index.
- mem_wdata  output  32  instruction word.
- cpu_hold  output  1  stall/hold request to the CPU.
- busy  output  1  session in progress.
- done  output  1  last session completed successfully; sticky until next start.
- error  output  1  last session failed; sticky until next start.

Behaviour:
- Reset: asynchronous and active-low. All outputs are 0, including cpu_hold. FSM goes to IDLE; index, shift register and checksum clear.
- Stream format, all big-endian:
  - 2 header bytes: word count N.
  - N*4 payload bytes, MSB first per word.
  - 1 checksum byte equal to the XOR of all payload bytes. Header bytes are not included.
- FSM states: IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHK, DONE, ERR.
- IDLE/DONE/ERR:
  - byte_ready=0.
  - start -> HDR_HI. Clears done, error, index and checksum; sets busy=1 and cpu_hold=1 on the next cycle.
  - start is ignored in every other state.
- HDR_HI: byte_ready=1. On a transfer, latch N[15:8] -> HDR_LO.
- HDR_LO: byte_ready=1. On a transfer, latch N[7:0], then:
  - if N==0 or N>MAX_WORDS -> ERR;
  - otherwise -> DATA.
- DATA:
  - byte_ready=1.
  - Each transfer shifts the byte into a 32-bit register (left shift, new byte in [7:0]) and XORs it into the checksum.
  - On the 4th byte of a word -> WRITE.
- WRITE:
  - byte_ready=0.
  - mem_we=1 for exactly this cycle, with mem_wdata = the assembled word and mem_addr = BASE_ADDR + (index<<2).
  - index increments. If the new index == N -> CHK, else -> DATA.
  - Latency: mem_we is asserted the cycle after the 4th byte transfer.
- CHK: byte_ready=1. On a transfer, compare with the accumulated XOR:
  - match -> DONE;
  - mismatch -> ERR.
- DONE: busy=0, done=1, cpu_hold=0.
- ERR: busy=0, error=1, cpu_hold stays 1 so the CPU never runs a partial image. A new start retries.
- Output defaults:
  - mem_we is 0 outside WRITE.
  - mem_addr/mem_wdata hold their last values when mem_we=0; they are don't-care to the RAM.
- Flow control: byte_valid gaps of any length in any receiving state cause no state change.
- Index and address arithmetic is CNT_W bits; N<=MAX_WORDS guarantees no wrap. mem_addr is computed in 32 bits with wrap-around.
- Reset mid-session: immediate return to reset values. No further mem_we; cpu_hold drops to 0.
- byte_valid while byte_ready=0: the byte is not consumed; the source must hold it.

Decomposition:
- Shared package holds:
  - FSM state encoding (3-bit localparams);
  - the stream format constants: header length 2, bytes per word 4, checksum length 1;
  - the word-alignment shift of 2.
- One natural sub-module: loader_word_asm, the byte-to-word shift register with a byte counter and XOR checksum accumulator. It has clear/enable inputs and word_full/word/checksum outputs.
- The top level keeps the FSM, index, header decode and memory/CPU outputs.

Test Plan:
- Good load. start, then bytes 00 02 20 08 00 02 20 09 00 01 02 ->
  - mem_we pulses twice: addr 0x00000000 data 0x20080002, then addr 0x00000004 data 0x20090001;
  - done=1, error=0, cpu_hold 1->0, busy 1->0.
- Bad checksum. Same stream with checksum 03 -> both writes occur, error=1, done=0, cpu_hold remains 1.
- Bad header. Header 00 00 -> error=1 right after the 2nd byte, no mem_we. Header 01 01 (257 > MAX_WORDS) -> same result.
- Flow control. Good-load stream with byte_valid deasserted 0-5 random cycles between bytes -> identical writes and result. byte_ready=0 in each WRITE cycle, and the presented byte is held, not lost.
- Reset mid-session. reset_n low after the 6th byte of the good load -> all outputs 0 asynchronously, only the first word written. A subsequent full good load succeeds.
- Busy/restart. start pulsed during DATA is ignored and the load completes normally. start after ERR -> error clears and the retry with a good stream sets done=1.

Source files
------------

// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM encoding,
// stream framing constants and the word-address helper.
package inst_mem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CHK_BYTES  = 1;
    localparam int unsigned WORD_SHIFT = 2;
    localparam int unsigned BYTE_CNT_W = $clog2(WORD_BYTES);

    // Byte address of a word slot; wraps naturally in 32 bits.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [31:0] index);
        return base + (index << WORD_SHIFT);
    endfunction

endpackage

// File: rtl/inst_mem_loader_word_asm.sv
// Byte-to-word assembler: big-endian shift register, byte counter and
// running XOR checksum over every accepted byte.
module loader_word_asm
    import inst_mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic        o_word_full,
    output logic [31:0] o_word,
    output logic [7:0]  o_checksum
);

    logic [BYTE_CNT_W-1:0] r_cnt;
    logic [31:0]           r_word;
    logic [7:0]            r_chk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_word <= '0;
            r_chk  <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_word <= '0;
            r_chk  <= '0;
        end else if (i_en) begin
            r_cnt  <= r_cnt + BYTE_CNT_W'(1);
            r_word <= {r_word[23:0], i_byte};
            r_chk  <= r_chk ^ i_byte;
        end
    end

    // Flags the byte that completes a word, in the cycle it is accepted.
    assign o_word_full = i_en && (r_cnt == BYTE_CNT_W'(WORD_BYTES - 1));
    assign o_word      = r_word;
    assign o_checksum  = r_chk;

endmodule

// File: rtl/inst_mem_loader.sv
// Fills the instruction RAM from a framed byte stream (header, payload,
// XOR checksum) while holding the CPU stalled until a clean load completes.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_hdr_hi;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_index;
    logic [31:0]        r_addr_hold;
    logic [31:0]        r_wdata_hold;

    logic               w_xfer;
    logic               w_start_ok;
    logic               w_asm_en;
    logic               w_word_full;
    logic [31:0]        w_word;
    logic [7:0]         w_checksum;
    logic [CNT_W-1:0]   w_hdr_n;
    logic               w_hdr_bad;
    logic [CNT_W-1:0]   w_index_nxt;
    logic               w_last_word;
    logic               w_chk_ok;
    logic [31:0]        w_addr;

    assign w_xfer      = byte_valid && byte_ready;
    assign w_start_ok  = start && (r_state inside {S_IDLE, S_DONE, S_ERR});
    assign w_asm_en    = (r_state == S_DATA) && w_xfer;
    assign w_hdr_n     = CNT_W'({r_hdr_hi, byte_data});
    assign w_hdr_bad   = (w_hdr_n == '0) || (w_hdr_n > CNT_W'(MAX_WORDS));
    assign w_index_nxt = r_index + CNT_W'(1);
    assign w_last_word = (w_index_nxt == r_count);
    assign w_chk_ok    = (byte_data == w_checksum);
    assign w_addr      = word_addr(BASE_ADDR, 32'(r_index));

    loader_word_asm u_word_asm (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clear     (w_start_ok),
        .i_en        (w_asm_en),
        .i_byte      (byte_data),
        .o_word_full (w_word_full),
        .o_word      (w_word),
        .o_checksum  (w_checksum)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_HDR_HI;
            end
            S_HDR_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                cpu_hold   = 1'b1;
                if (w_xfer) w_next = S_HDR_LO;
            end
            S_HDR_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                cpu_hold   = 1'b1;
                if (w_xfer) w_next = w_hdr_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                cpu_hold   = 1'b1;
                if (w_word_full) w_next = S_WRITE;
            end
            S_WRITE: begin
                mem_we   = 1'b1;
                busy     = 1'b1;
                cpu_hold = 1'b1;
                w_next   = w_last_word ? S_CHK : S_DATA;
            end
            S_CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                cpu_hold   = 1'b1;
                if (w_xfer) w_next = w_chk_ok ? S_DONE : S_ERR;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) w_next = S_HDR_HI;
            end
            S_ERR: begin
                error    = 1'b1;
                cpu_hold = 1'b1;
                if (start) w_next = S_HDR_HI;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hdr_hi     <= '0;
            r_count      <= '0;
            r_index      <= '0;
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
        end else begin
            if (w_start_ok) begin
                r_index <= '0;
            end
            if ((r_state == S_HDR_HI) && w_xfer) begin
                r_hdr_hi <= byte_data;
            end
            if ((r_state == S_HDR_LO) && w_xfer) begin
                r_count <= w_hdr_n;
            end
            if (r_state == S_WRITE) begin
                r_index      <= w_index_nxt;
                r_addr_hold  <= w_addr;
                r_wdata_hold <= w_word;
            end
        end
    end

    // Live values during WRITE; afterwards the last written pair is held
    // even though the index has already advanced.
    assign mem_addr  = (r_state == S_WRITE) ? w_addr : r_addr_hold;
    assign mem_wdata = (r_state == S_WRITE) ? w_word : r_wdata_hold;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: framed loads, bad checksum/header,
// flow-control gaps, mid-session reset and restart behaviour.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          wcount   = 0;
    logic [31:0] waddr [0:7];
    logic [31:0] wdata [0:7];
    logic [7:0]  tx    [0:10];
    int          gaps  [0:10] = '{3, 0, 5, 1, 2, 4, 0, 5, 3, 1, 2};

    inst_mem_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (256),
        .CNT_W     (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            check_val("ready_in_write", 32'(byte_ready), 32'd0);
            if (wcount < 8) begin
                waddr[wcount] = mem_addr;
                wdata[wcount] = mem_wdata;
            end
            wcount++;
        end
    end

    task automatic set_good_stream();
        tx = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h02,
               8'h20, 8'h09, 8'h00, 8'h01, 8'h02};
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) check_val("ready_timeout", 32'(byte_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_stream(input int len, input bit use_gaps,
                               input int start_after);
        for (int i = 0; i < len; i++) begin
            send_byte(tx[i], use_gaps ? gaps[i] : 0);
            if (i + 1 == start_after) begin
                @(negedge clk);
                byte_valid = 1'b0;
                start      = 1'b1;
                @(negedge clk);
                start      = 1'b0;
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic [3:0] exp);
        check_val(tag, 32'({busy, cpu_hold, done, error}), 32'(exp));
    endtask

    task automatic check_two_words(input string tag);
        check_val({tag, "_wcount"}, 32'(wcount), 32'd2);
        check_val({tag, "_addr0"}, waddr[0], 32'h0000_0000);
        check_val({tag, "_data0"}, wdata[0], 32'h2008_0002);
        check_val({tag, "_addr1"}, waddr[1], 32'h0000_0004);
        check_val({tag, "_data1"}, wdata[1], 32'h2009_0001);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_ctrl", 32'({byte_ready, mem_we, cpu_hold, busy, done, error}), 32'd0);
        check_val("rst_addr", mem_addr, 32'd0);
        check_val("rst_wdata", mem_wdata, 32'd0);
        reset_n = 1'b1;

        // Good load, no gaps
        set_good_stream();
        wcount = 0;
        pulse_start();
        check_status("good_start", 4'b1100);
        send_stream(11, 1'b0, 0);
        check_status("good_end", 4'b0010);
        check_two_words("good");

        // Bad checksum
        tx[10] = 8'h03;
        wcount = 0;
        pulse_start();
        check_status("badchk_start", 4'b1100);
        send_stream(11, 1'b0, 0);
        check_status("badchk_end", 4'b0101);
        check_two_words("badchk");

        // Header N=0
        tx[0] = 8'h00;
        tx[1] = 8'h00;
        wcount = 0;
        pulse_start();
        check_status("hdr0_start", 4'b1100);
        send_stream(2, 1'b0, 0);
        check_status("hdr0_end", 4'b0101);
        check_val("hdr0_wcount", 32'(wcount), 32'd0);

        // Header N=257
        tx[0] = 8'h01;
        tx[1] = 8'h01;
        pulse_start();
        check_status("hdr257_start", 4'b1100);
        send_stream(2, 1'b0, 0);
        check_status("hdr257_end", 4'b0101);
        check_val("hdr257_wcount", 32'(wcount), 32'd0);

        // Retry after error with flow-control gaps
        set_good_stream();
        wcount = 0;
        pulse_start();
        check_status("gaps_start", 4'b1100);
        send_stream(11, 1'b1, 0);
        check_status("gaps_end", 4'b0010);
        check_two_words("gaps");

        // start pulsed during DATA is ignored
        wcount = 0;
        pulse_start();
        send_stream(11, 1'b0, 4);
        check_status("midstart_end", 4'b0010);
        check_two_words("midstart");

        // Reset after the 6th byte
        wcount = 0;
        pulse_start();
        send_stream(6, 1'b0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("midrst_ctrl", 32'({byte_ready, mem_we, cpu_hold, busy, done, error}), 32'd0);
        check_val("midrst_addr", mem_addr, 32'd0);
        check_val("midrst_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        check_val("midrst_wcount", 32'(wcount), 32'd1);
        check_val("midrst_data0", wdata[0], 32'h2008_0002);
        reset_n = 1'b1;

        wcount = 0;
        pulse_start();
        send_stream(11, 1'b0, 0);
        check_status("postrst_end", 4'b0010);
        check_two_words("postrst");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
